rv32_debug_reg_arbiter: RTL
===========================

Name: rv32_debug_reg_arbiter

Overview:
- Shares the decode stage's register file between the pipeline writeback path and an external debug requester (debug module or host bridge).
- On a debug request it stalls the pipeline and waits for it to drain. It then takes the register file read address and write port for one access and returns a response.
- Sits between writeback, the hazard unit (its stall is ORed into the decode/fetch stall) and the register file instance inside decode.

Parameters:
- DRAIN_TIMEOUT, 16, maximum cycles spent waiting for pipe_idle_in before the request is aborted with error.
- TIMEOUT_W, $clog2(DRAIN_TIMEOUT+1), width of the drain counter (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- dbg_req_in  in  1  debug request; held high with fields stable until dbg_ready_out.
- dbg_write_in  in  1  1 = register write, 0 = register read.
- dbg_addr_in  in  5  target register x0..x31.
- dbg_wdata_in  in  32  write data.
- dbg_ready_out  out  1  one-cycle completion pulse.
- dbg_rdata_out  out  32  read data, valid when dbg_ready_out is high.
- dbg_err_out  out  1  drain timeout; valid when dbg_ready_out is high.
- pipe_idle_in  in  1  from hazard: no valid instruction in decode..writeback.
- pipe_stall_out  out  1  to hazard: freeze fetch/decode.
- wb_rd_in  in  5  writeback destination.
- wb_rd_write_in  in  1  writeback write enable.
- wb_rd_value_in  in  32  writeback data.
- rf_rs1_sel_in  in  5  decode's rs1 field.
- rf_rs1_out  out  5  rs1 address to register file.
- rf_rs1_value_in  in  32  register file rs1 read data (registered, 1-cycle latency).
- rf_rd_out  out  5  register file write address.
- rf_rd_write_out  out  1  register file write enable.
- rf_rd_value_out  out  32  register file write data.

Behaviour:
- Reset (async on reset_n low, released synchronously): state=IDLE, pipe_stall_out=0, dbg_ready_out=0, dbg_err_out=0, dbg_rdata_out=0, drain counter=0, latched request cleared.
- States: IDLE, DRAIN, ACCESS, CAPTURE, RESP.
- IDLE:
  - Passthrough: rf_rs1_out=rf_rs1_sel_in; rf_rd_*=wb_rd_*.
  - If dbg_req_in is high, latch write/addr/wdata, clear the counter and go to DRAIN.
- DRAIN:
  - pipe_stall_out=1; writeback passthrough continues so in-flight instructions retire.
  - If pipe_idle_in, go to ACCESS.
  - Otherwise, if counter==DRAIN_TIMEOUT, go to RESP with error set.
  - Otherwise increment the counter.
- ACCESS:
  - pipe_stall_out=1; writeback passthrough is blocked (the pipeline is idle, so wb_rd_write_in is ignored).
  - Write: rf_rd_out=addr, rf_rd_value_out=wdata, rf_rd_write_out=(addr!=0); go to RESP.
  - Read: rf_rs1_out=addr; go to CAPTURE.
- CAPTURE:
  - pipe_stall_out=1; rf_rs1_out still = addr.
  - Register dbg_rdata_out = (addr==0) ? 0 : rf_rs1_value_in; go to RESP.
- RESP:
  - dbg_ready_out=1 for exactly this cycle; dbg_err_out=error flag.
  - pipe_stall_out=1 this cycle; go to IDLE, where the stall drops.
  - dbg_rdata_out is 0 for writes and errors.
  - A new request is not accepted in RESP; earliest acceptance is the IDLE cycle that follows.
- Latency, no drain wait: write = 3 cycles from req sample to ready; read = 4 cycles.
- Request withdrawn mid-operation: ignored; the latched operation completes and still pulses ready.
- pipe_idle_in high in the first DRAIN cycle: go to ACCESS next cycle (no minimum wait).
- Timeout: the counter saturates and no register is touched; pipe_stall_out still drops after RESP.
- Reset mid-operation: abort immediately, no write, no ready pulse; the pipeline is released.
- Writes to x0 are suppressed; reads of x0 return 0.

Decomposition:
- Package rv32_debug_pkg: state enum (IDLE/DRAIN/ACCESS/CAPTURE/RESP) and the DRAIN_TIMEOUT default constant.
- No sub-module; the register-file port mux is an always_comb block inside the arbiter.

Test Plan:
- Write: reset, then req write x5=0xDEADBEEF with pipe_idle_in=1 -> stall high from cycle 1; rf_rd_write_out=1/rd=5 in ACCESS; ready pulse at cycle 3 with err=0; stall low at cycle 4.
- Readback: read x5 after the write -> rdata=0xDEADBEEF, ready at cycle 4; a read of x0 -> rdata=0 and rf_rd_write_out never asserted.
- Drain: pipe_idle_in low 5 cycles while wb writes x3=0x11 -> x3 written during DRAIN, ACCESS begins the cycle after idle rises, debug write is not lost.
- Timeout: pipe_idle_in held low -> after DRAIN_TIMEOUT+1 DRAIN cycles, ready=1 with err=1; no rf write; stall released the next cycle.
- Withdrawal and back-to-back: req dropped after 1 cycle -> operation still completes; two reqs back-to-back -> second accepted only in the IDLE cycle after RESP.
- Reset: reset_n asserted in ACCESS -> all outputs 0 asynchronously; no ready pulse after release.

Source files
------------

// File: rtl/rv32_debug_pkg.sv
// rtl/rv32_debug_pkg.sv - shared state encoding and defaults for the debug register arbiter
package rv32_debug_pkg;

    localparam int DRAIN_TIMEOUT_DEFAULT = 16;

    typedef logic [2:0] dbg_state_t;

    localparam dbg_state_t ST_IDLE    = 3'd0;
    localparam dbg_state_t ST_DRAIN   = 3'd1;
    localparam dbg_state_t ST_ACCESS  = 3'd2;
    localparam dbg_state_t ST_CAPTURE = 3'd3;
    localparam dbg_state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/rv32_debug_reg_arbiter.sv
// rtl/rv32_debug_reg_arbiter.sv - arbitrates the decode register file between writeback and a debug requester
module rv32_debug_reg_arbiter
    import rv32_debug_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    localparam int TIMEOUT_W = $clog2(DRAIN_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dbg_req_in,
    input  logic        dbg_write_in,
    input  logic [4:0]  dbg_addr_in,
    input  logic [31:0] dbg_wdata_in,
    output logic        dbg_ready_out,
    output logic [31:0] dbg_rdata_out,
    output logic        dbg_err_out,
    input  logic        pipe_idle_in,
    output logic        pipe_stall_out,
    input  logic [4:0]  wb_rd_in,
    input  logic        wb_rd_write_in,
    input  logic [31:0] wb_rd_value_in,
    input  logic [4:0]  rf_rs1_sel_in,
    output logic [4:0]  rf_rs1_out,
    input  logic [31:0] rf_rs1_value_in,
    output logic [4:0]  rf_rd_out,
    output logic        rf_rd_write_out,
    output logic [31:0] rf_rd_value_out
);

    dbg_state_t           state;
    logic [TIMEOUT_W-1:0] drain_cnt;
    logic                 req_write;
    logic [4:0]           req_addr;
    logic [31:0]          req_wdata;
    logic                 err_q;
    logic [31:0]          rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            req_write <= 1'b0;
            req_addr  <= 5'd0;
            req_wdata <= 32'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_req_in) begin
                        req_write <= dbg_write_in;
                        req_addr  <= dbg_addr_in;
                        req_wdata <= dbg_wdata_in;
                        drain_cnt <= '0;
                        err_q     <= 1'b0;
                        rdata_q   <= 32'd0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_idle_in) begin
                        state <= ST_ACCESS;
                    end else if (drain_cnt == TIMEOUT_W'(DRAIN_TIMEOUT)) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state <= req_write ? ST_RESP : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Register file read data arrives one cycle after the address was driven in ACCESS
                    rdata_q <= (req_addr == 5'd0) ? 32'd0 : rf_rs1_value_in;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rf_rs1_out      = rf_rs1_sel_in;
        rf_rd_out       = wb_rd_in;
        rf_rd_write_out = wb_rd_write_in;
        rf_rd_value_out = wb_rd_value_in;
        if (state == ST_ACCESS) begin
            // Pipeline is drained here, so writeback is deliberately ignored
            rf_rs1_out      = req_addr;
            rf_rd_out       = req_addr;
            rf_rd_value_out = req_wdata;
            rf_rd_write_out = req_write && (req_addr != 5'd0);
        end else if (state == ST_CAPTURE) begin
            rf_rs1_out = req_addr;
        end
    end

    assign pipe_stall_out = (state != ST_IDLE);
    assign dbg_ready_out  = (state == ST_RESP);
    assign dbg_err_out    = dbg_ready_out & err_q;
    assign dbg_rdata_out  = rdata_q;

endmodule
